// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and constants for the register-file access controller.
package regfile_access_ctrl_pkg;

    localparam int NUM_REQ = 2;

    // Sequencer states: one register-file access takes SETUP, STROBE, CAPTURE.
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_CAPTURE = 3'd4
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/regfile_access_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer holds the last granted requester;
// on contention the other requester wins. The pointer only moves when the
// grant is actually taken, so a requester that withdraws loses nothing.
module rr_arbiter2
    import regfile_access_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection and pointer update on an accepted grant.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b01 : 2'b10;
        end
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = grant[1];
        end
    end

    // Pointer register; reset value 1 lets requester 0 win first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequencer and two-requester arbiter for a strobe-driven register file.
// Each accepted request runs SETUP -> STROBE -> CAPTURE so that indices and
// data are stable a full cycle before and after each one-cycle strobe.
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int NAME_BITS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*NAME_BITS-1:0] req_rs1,
    input  logic [NUM_REQ*NAME_BITS-1:0] req_rs2,
    input  logic [NUM_REQ*NAME_BITS-1:0] req_ws,
    input  logic [NUM_REQ*REG_WIDTH-1:0] req_wd,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [REG_WIDTH-1:0]         rsp_rd1,
    output logic [REG_WIDTH-1:0]         rsp_rd2,
    output logic                         rf_rst,
    output logic                         rf_write,
    output logic                         rf_read,
    output logic [NAME_BITS-1:0]         rf_rs1,
    output logic [NAME_BITS-1:0]         rf_rs2,
    output logic [NAME_BITS-1:0]         rf_ws,
    output logic [REG_WIDTH-1:0]         rf_wd,
    input  logic [REG_WIDTH-1:0]         rf_rd1,
    input  logic [REG_WIDTH-1:0]         rf_rd2
);

    state_t                 state_q, state_d;
    op_t                    op_q, op_d;
    logic                   id_q, id_d;
    logic                   rf_rst_q, rf_rst_d;
    logic                   rf_write_q, rf_write_d;
    logic                   rf_read_q, rf_read_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [REG_WIDTH-1:0]   rsp_rd1_q, rsp_rd1_d;
    logic [REG_WIDTH-1:0]   rsp_rd2_q, rsp_rd2_d;
    logic [NAME_BITS-1:0]   rf_rs1_q, rf_rs1_d;
    logic [NAME_BITS-1:0]   rf_rs2_q, rf_rs2_d;
    logic [NAME_BITS-1:0]   rf_ws_q, rf_ws_d;
    logic [REG_WIDTH-1:0]   rf_wd_q, rf_wd_d;

    logic [NUM_REQ-1:0]     grant;
    logic                   accept;
    logic                   gnt_id;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Requests are only taken in IDLE; grant is one-hot or zero.
    always_comb begin
        req_ready = (state_q == ST_IDLE) ? grant : '0;
        accept    = |req_ready;
        gnt_id    = grant[1];
    end

    // Next-state and registered-output logic. Strobes and rsp_valid default
    // low so each is a single-cycle pulse; indices/data hold until the next
    // acceptance.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        id_d        = id_q;
        rf_rst_d    = 1'b0;
        rf_write_d  = 1'b0;
        rf_read_d   = 1'b0;
        rsp_valid_d = '0;
        rsp_rd1_d   = rsp_rd1_q;
        rsp_rd2_d   = rsp_rd2_q;
        rf_rs1_d    = rf_rs1_q;
        rf_rs2_d    = rf_rs2_q;
        rf_ws_d     = rf_ws_q;
        rf_wd_d     = rf_wd_q;

        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    op_d     = req_we[gnt_id] ? OP_WRITE : OP_READ;
                    id_d     = gnt_id;
                    rf_rs1_d = gnt_id ? req_rs1[2*NAME_BITS-1:NAME_BITS] : req_rs1[NAME_BITS-1:0];
                    rf_rs2_d = gnt_id ? req_rs2[2*NAME_BITS-1:NAME_BITS] : req_rs2[NAME_BITS-1:0];
                    rf_ws_d  = gnt_id ? req_ws[2*NAME_BITS-1:NAME_BITS]  : req_ws[NAME_BITS-1:0];
                    rf_wd_d  = gnt_id ? req_wd[2*REG_WIDTH-1:REG_WIDTH]  : req_wd[REG_WIDTH-1:0];
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // r0 is hardwired; a write to it completes without a strobe.
                rf_read_d  = (op_q == OP_READ);
                rf_write_d = (op_q == OP_WRITE) && (rf_ws_q != '0);
                state_d    = ST_STROBE;
            end
            ST_STROBE: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (op_q == OP_READ) begin
                    rsp_rd1_d = rf_rd1;
                    rsp_rd2_d = rf_rd2;
                end
                rsp_valid_d[id_q] = 1'b1;
                state_d           = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State and output registers; reset kills any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            op_q        <= OP_READ;
            id_q        <= 1'b0;
            rf_rst_q    <= 1'b1;
            rf_write_q  <= 1'b0;
            rf_read_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rd1_q   <= '0;
            rsp_rd2_q   <= '0;
            rf_rs1_q    <= '0;
            rf_rs2_q    <= '0;
            rf_ws_q     <= '0;
            rf_wd_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rf_rst_q    <= rf_rst_d;
            rf_write_q  <= rf_write_d;
            rf_read_q   <= rf_read_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rd1_q   <= rsp_rd1_d;
            rsp_rd2_q   <= rsp_rd2_d;
            rf_rs1_q    <= rf_rs1_d;
            rf_rs2_q    <= rf_rs2_d;
            rf_ws_q     <= rf_ws_d;
            rf_wd_q     <= rf_wd_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rd1   = rsp_rd1_q;
    assign rsp_rd2   = rsp_rd2_q;
    assign rf_rst    = rf_rst_q;
    assign rf_write  = rf_write_q;
    assign rf_read   = rf_read_q;
    assign rf_rs1    = rf_rs1_q;
    assign rf_rs2    = rf_rs2_q;
    assign rf_ws     = rf_ws_q;
    assign rf_wd     = rf_wd_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural strobe-driven
// register file attached to the rf_* side.
module tb_regfile_access_ctrl;

    localparam int RW = 32;
    localparam int NB = 5;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*NB-1:0] req_rs1;
    logic [2*NB-1:0] req_rs2;
    logic [2*NB-1:0] req_ws;
    logic [2*RW-1:0] req_wd;
    logic [1:0]      rsp_valid;
    logic [RW-1:0]   rsp_rd1;
    logic [RW-1:0]   rsp_rd2;
    logic            rf_rst;
    logic            rf_write;
    logic            rf_read;
    logic [NB-1:0]   rf_rs1;
    logic [NB-1:0]   rf_rs2;
    logic [NB-1:0]   rf_ws;
    logic [RW-1:0]   rf_wd;
    logic [RW-1:0]   rf_rd1;
    logic [RW-1:0]   rf_rd2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [RW-1:0] prev_rd1 = '0;
    logic [RW-1:0] prev_rd2 = '0;

    regfile_access_ctrl #(.REG_WIDTH(RW), .NAME_BITS(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_ws    (req_ws),
        .req_wd    (req_wd),
        .rsp_valid (rsp_valid),
        .rsp_rd1   (rsp_rd1),
        .rsp_rd2   (rsp_rd2),
        .rf_rst    (rf_rst),
        .rf_write  (rf_write),
        .rf_read   (rf_read),
        .rf_rs1    (rf_rs1),
        .rf_rs2    (rf_rs2),
        .rf_ws     (rf_ws),
        .rf_wd     (rf_wd),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: edge-triggered on its strobes, r0 reads 0.
    logic [RW-1:0] regs [32];
    always @(posedge rf_rst) begin
        for (int i = 0; i < 32; i++) regs[i] <= '0;
    end
    always @(posedge rf_write) begin
        if (rf_ws != '0) regs[rf_ws] <= rf_wd;
    end
    always @(posedge rf_read) begin
        rf_rd1 <= regs[rf_rs1];
        rf_rd2 <= regs[rf_rs2];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Strobes must never overlap each other or the reset strobe.
    always @(negedge clk) begin
        chk("strobe_excl", {63'd0, (rf_read & rf_write) | ((rf_read | rf_write) & rf_rst)}, 64'd0);
    end

    task automatic set_req(input int id, input bit we, input logic [NB-1:0] rs1,
                           input logic [NB-1:0] rs2, input logic [NB-1:0] ws,
                           input logic [RW-1:0] wd);
        req_we[id]           = we;
        req_rs1[id*NB +: NB] = rs1;
        req_rs2[id*NB +: NB] = rs2;
        req_ws[id*NB +: NB]  = ws;
        req_wd[id*RW +: RW]  = wd;
    endtask

    // Wait (bounded) at the falling edge for requester id to be granted.
    task automatic wait_ready(input int id, input string tag);
        int n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {62'd0, req_ready}, 64'd1 << id);
    endtask

    // One complete transaction with per-edge checks of strobes, indices and
    // the response. With perturb set, the requester's fields are scrambled
    // after acceptance to show they are not re-sampled.
    task automatic do_op(input string tag, input int id, input bit we,
                         input logic [NB-1:0] rs1, input logic [NB-1:0] rs2,
                         input logic [NB-1:0] ws, input logic [RW-1:0] wd,
                         input bit perturb,
                         input logic [RW-1:0] exp1, input logic [RW-1:0] exp2);
        logic exp_w;
        exp_w = we && (ws != '0);
        set_req(id, we, rs1, rs2, ws, wd);
        req_valid = 2'b00;
        req_valid[id] = 1'b1;
        wait_ready(id, tag);
        @(posedge clk); #1;                        // E0 + 1
        req_valid = 2'b00;
        if (perturb) set_req(id, we, rs1 + 5'd2, rs2, ws + 5'd2, ~wd);
        chk({tag, "_setup_strb"}, {62'd0, rf_write, rf_read}, 64'd0);
        chk({tag, "_setup_ws"}, {59'd0, rf_ws}, {59'd0, ws});
        @(posedge clk); #1;                        // E1 + 1
        if (perturb) set_req(id, we, rs1, rs2, ws + 5'd4, 32'h1234_5678);
        chk({tag, "_strb"}, {62'd0, rf_write, rf_read}, {62'd0, exp_w, ~we});
        chk({tag, "_strb_ws"}, {59'd0, rf_ws}, {59'd0, ws});
        chk({tag, "_strb_wd"}, {32'd0, rf_wd}, {32'd0, wd});
        chk({tag, "_strb_rs"}, {54'd0, rf_rs1, rf_rs2}, {54'd0, rs1, rs2});
        @(posedge clk); #1;                        // E2 + 1
        chk({tag, "_cap_strb"}, {62'd0, rf_write, rf_read}, 64'd0);
        chk({tag, "_cap_wd"}, {32'd0, rf_wd}, {32'd0, wd});
        chk({tag, "_cap_rsp"}, {62'd0, rsp_valid}, 64'd0);
        @(posedge clk); #1;                        // E3 + 1
        chk({tag, "_rsp_valid"}, {62'd0, rsp_valid}, 64'd1 << id);
        if (!we) begin
            prev_rd1 = exp1;
            prev_rd2 = exp2;
        end
        chk({tag, "_rsp_rd1"}, {32'd0, rsp_rd1}, {32'd0, prev_rd1});
        chk({tag, "_rsp_rd2"}, {32'd0, rsp_rd2}, {32'd0, prev_rd2});
        @(posedge clk); #1;
        chk({tag, "_rsp_pulse"}, {62'd0, rsp_valid}, 64'd0);
        $display("[TB] %s: req%0d %s rs1=%0d rs2=%0d ws=%0d wd=%08h -> rd1=%08h rd2=%08h",
                 tag, id, we ? "WR" : "RD", rs1, rs2, ws, wd, rsp_rd1, rsp_rd2);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_we    = '0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_ws    = '0;
        req_wd    = '0;

        // 1. Reset state and the post-reset rf_rst cycle.
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b01;
        chk("rst_rf_rst", {63'd0, rf_rst}, 64'd1);
        chk("rst_strobes", {62'd0, rf_write, rf_read}, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_idx", {49'd0, rf_rs1, rf_rs2, rf_ws}, 64'd0);
        chk("rst_data", {rf_wd, rsp_rd1}, 64'd0);
        chk("rst_ready", {62'd0, req_ready}, 64'd0);
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("init_rf_rst", {63'd0, rf_rst}, 64'd1);
        chk("init_ready", {62'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("idle_rf_rst", {63'd0, rf_rst}, 64'd0);
        $display("[TB] reset: rf_rst released one cycle after rst");

        do_op("t1_rd_r0_r31", 0, 1'b0, 5'd0, 5'd31, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        do_op("t1_wr_r31",    0, 1'b1, 5'd0, 5'd0, 5'd31, 32'd0, 1'b0, 32'd0, 32'd0);
        do_op("t1_rd_r31_r0", 0, 1'b0, 5'd31, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        // 2. Write then read back through requester 0.
        do_op("t2_wr_r1", 0, 1'b1, 5'd0, 5'd0, 5'd1, 32'd1, 1'b0, 32'd0, 32'd0);
        do_op("t2_rd_r1", 0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'd1, 32'd0);

        // 4. Write to r0 completes without a strobe; r0 still reads 0.
        do_op("t4_wr_r0", 1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0);
        do_op("t4_rd_r0", 1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);

        // 3. Both requesters continuously valid; last grant was requester 1,
        //    so grants go 0, 1, 0, 1.
        set_req(0, 1'b1, 5'd0, 5'd0, 5'd31, 32'd3);
        set_req(1, 1'b0, 5'd31, 5'd1, 5'd0, 32'd0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            int exp_id;
            exp_id = k % 2;
            @(negedge clk);
            while (req_ready == 2'b00 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t3_grant", {62'd0, req_ready}, 64'd1 << exp_id);
            @(posedge clk);
            repeat (3) @(posedge clk);
            #1;
            if (k == 3) req_valid = 2'b00;
            chk("t3_rsp_valid", {62'd0, rsp_valid}, 64'd1 << exp_id);
            if (exp_id == 1) begin
                prev_rd1 = 32'd3;
                prev_rd2 = 32'd1;
            end
            chk("t3_rsp_data", {rsp_rd1, rsp_rd2}, {prev_rd1, prev_rd2});
            $display("[TB] t3_rr: grant req%0d rsp_valid=%b rd1=%08h rd2=%08h",
                     exp_id, rsp_valid, rsp_rd1, rsp_rd2);
        end

        // 5. Inputs changed after acceptance have no effect.
        do_op("t5_wr_r5", 0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hA5A50F0F, 1'b1, 32'd0, 32'd0);
        do_op("t5_rd_r5_r7", 0, 1'b0, 5'd5, 5'd7, 5'd0, 32'd0, 1'b0, 32'hA5A50F0F, 32'd0);

        // 6. Asynchronous reset while rf_read is high.
        set_req(0, 1'b0, 5'd1, 5'd5, 5'd0, 32'd0);
        req_valid = 2'b01;
        wait_ready(0, "t6");
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        chk("t6_rf_read_hi", {63'd0, rf_read}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rf_read_drop", {63'd0, rf_read}, 64'd0);
        chk("t6_rf_rst", {63'd0, rf_rst}, 64'd1);
        chk("t6_ready", {62'd0, req_ready}, 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("t6_no_rsp", {62'd0, rsp_valid}, 64'd0);
        end
        rst = 1'b0;
        prev_rd1 = '0;
        prev_rd2 = '0;
        chk("t6_rsp_cleared", {rsp_rd1, rsp_rd2}, 64'd0);
        @(negedge clk);
        chk("t6_init_rf_rst", {63'd0, rf_rst}, 64'd1);
        @(posedge clk); #1;
        chk("t6_rf_rst_low", {63'd0, rf_rst}, 64'd0);
        chk("t6_no_rsp_after", {62'd0, rsp_valid}, 64'd0);
        $display("[TB] t6: reset during read strobe, in-flight read dropped");
        do_op("t6_wr_r2", 0, 1'b1, 5'd0, 5'd0, 5'd2, 32'h55, 1'b0, 32'd0, 32'd0);
        do_op("t6_rd_r2_r1", 0, 1'b0, 5'd2, 5'd1, 5'd0, 32'd0, 1'b0, 32'h55, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
